// File: rtl/rrb_pkg.sv
// Shared types, defaults and grant helpers for the weighted round-robin arbiter slice.
// Occupancy codes are plain localparams so legacy users can compare against raw values.
package rrb_pkg;

  localparam int unsigned RRB_CHANNELS = 8;
  localparam int unsigned RRB_WIDTH    = 32;
  localparam int unsigned RRB_MAX_CH   = 64;

  localparam logic [1:0] OccEmpty = 2'd0;
  localparam logic [1:0] OccOne   = 2'd1;
  localparam logic [1:0] OccFull  = 2'd2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [RRB_MAX_CH-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  // Only meaningful for a one-hot input; multi-hot vectors OR their indices together.
  function automatic logic [5:0] onehot_to_idx(input logic [RRB_MAX_CH-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < RRB_MAX_CH; i++) begin
      if (v[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rrb_skid_fifo.sv
// Two-entry FIFO of {data, channel index}; head register feeds the output directly.
// Reset is synchronous, active-low.
module rrb_skid_fifo
  import rrb_pkg::*;
#(
  parameter int unsigned Width = 35
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic             do_push, do_pop;

  assign full_o  = (state_q == OccFull);
  assign empty_o = (state_q == OccEmpty);
  assign rdata_o = head_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OccEmpty: begin
        if (do_push) begin
          head_d  = wdata_i;
          state_d = OccOne;
        end
      end
      OccOne: begin
        // Simultaneous push/pop replaces the head and stays at one entry.
        if (do_push && do_pop) begin
          head_d = wdata_i;
        end else if (do_push) begin
          tail_d  = wdata_i;
          state_d = OccFull;
        end else if (do_pop) begin
          state_d = OccEmpty;
        end
      end
      OccFull: begin
        if (do_pop) begin
          head_d  = tail_q;
          state_d = OccOne;
        end
      end
      default: state_d = OccEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= OccEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/rrb_grant_mux.sv
// Grant-driven data mux into a 2-entry output buffer with per-channel ack and error flag.
// Optional per-channel transfer counters are built when RRB_MUX_STATS_EN is defined.
module rrb_grant_mux
  import rrb_pkg::*;
#(
  parameter int unsigned CHANNELS = RRB_CHANNELS,
  parameter int unsigned WIDTH    = RRB_WIDTH,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       grant,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ack,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      grant_err,
  output logic [CHANNELS*16-1:0]    stat_count
);

  logic [RRB_MAX_CH-1:0] grant_ext;
  logic                  grant_onehot;
  logic                  grant_multi;
  logic [5:0]            grant_idx_full;
  logic [IDX_W-1:0]      grant_idx;
  logic [WIDTH-1:0]      sel_data;
  logic                  sel_valid;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic                  grant_err_q;
  logic                  unused_idx;

  always_comb begin
    grant_ext                 = '0;
    grant_ext[CHANNELS-1:0]   = grant;
    grant_onehot              = is_onehot(grant_ext);
    grant_multi               = (grant != '0) && !grant_onehot;
    grant_idx_full            = onehot_to_idx(grant_ext);
    grant_idx                 = grant_idx_full[IDX_W-1:0];
  end

  assign unused_idx = ^grant_idx_full;

  // AND-OR mux; only trusted when the grant is one-hot.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant[j]) begin
        sel_data  = sel_data | in_data[j*WIDTH +: WIDTH];
        sel_valid = sel_valid | in_valid[j];
      end
    end
  end

  // Full blocks push regardless of out_ready: no ready-through path to in_ack.
  assign push      = reset & grant_onehot & sel_valid & ~fifo_full;
  assign in_ack    = push ? grant : '0;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  rrb_skid_fifo #(
    .Width (WIDTH + IDX_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i ({sel_data, grant_idx}),
    .pop_i   (pop),
    .rdata_o ({out_data, out_chan}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) grant_err_q <= 1'b0;
    else        grant_err_q <= grant_multi;
  end

  assign grant_err = grant_err_q;

`ifdef RRB_MUX_STATS_EN
  logic [15:0] stat_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < CHANNELS; j++) stat_q[j] <= '0;
    end else begin
      for (int j = 0; j < CHANNELS; j++) begin
        if (push && grant[j] && (stat_q[j] != 16'hFFFF)) stat_q[j] <= stat_q[j] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int j = 0; j < CHANNELS; j++) stat_count[j*16 +: 16] = stat_q[j];
  end
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_rrb_grant_mux.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_rrb_grant_mux;

  localparam int CH = 8;
  localparam int W  = 32;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     grant, in_valid, in_ack;
  logic [CH*W-1:0]   in_data;
  logic [W-1:0]      out_data;
  logic [IW-1:0]     out_chan;
  logic              out_valid, out_ready, grant_err;
  logic [CH*16-1:0]  stat_count;

  rrb_grant_mux #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .IDX_W    (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .grant      (grant),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ack     (in_ack),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant_err  (grant_err),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] chan;
  } entry_t;

  entry_t      q[$];
  logic        m_err;
  int unsigned m_stat[CH];

  typedef struct {
    logic          rst;
    logic [CH-1:0] g;
    logic [CH-1:0] v;
    logic [W-1:0]  d;
    logic          rdy;
    logic [CH-1:0] ack;
    logic          ov;
    logic          cd;
    logic [W-1:0]  od;
    logic [IW-1:0] oc;
    logic          err;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [CH-1:0] g, input logic [CH-1:0] v,
                       input logic [W-1:0] d, input logic rdy);
    reset     = r;
    grant     = g;
    in_valid  = v;
    out_ready = rdy;
    for (int j = 0; j < CH; j++) in_data[j*W +: W] = g[j] ? d : (32'hDEAD_0000 + 32'(j));
  endtask

  function automatic logic [CH-1:0] model_ack();
    if (reset && ($countones(grant) == 1) && ((grant & in_valid) != '0) && (q.size() < 2))
      return grant;
    return '0;
  endfunction

  function automatic logic [CH*16-1:0] model_stats();
    logic [CH*16-1:0] s;
    for (int j = 0; j < CH; j++) s[j*16 +: 16] = 16'(m_stat[j]);
    return s;
  endfunction

  task automatic model_check();
    check("m_ack", 128'(in_ack), 128'(model_ack()));
    check("m_out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      check("m_out_data", 128'(out_data), 128'(q[0].data));
      check("m_out_chan", 128'(out_chan), 128'(q[0].chan));
    end
    check("m_grant_err", 128'(grant_err), 128'(m_err));
    check("m_stats", 128'(stat_count), 128'(model_stats()));
  endtask

  task automatic model_edge();
    logic [CH-1:0] a;
    int            idx;
    if (!reset) begin
      q.delete();
      m_err = 1'b0;
      for (int j = 0; j < CH; j++) m_stat[j] = 0;
    end else begin
      a = model_ack();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (a != '0) begin
        idx = 0;
        for (int j = 0; j < CH; j++) if (a[j]) idx = j;
        q.push_back({in_data[idx*W +: W], IW'(idx)});
`ifdef RRB_MUX_STATS_EN
        if (m_stat[idx] < 65535) m_stat[idx]++;
`endif
      end
      m_err = ($countones(grant) > 1);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs sampled on negedge.
  task automatic cycle_end();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'h08, 8'hFF, 32'h0,  1'b0, 8'h00, 1'b0, 1'b1, 32'h0,  3'd0, 1'b0};
    tbl[1]  = '{1'b0, 8'h08, 8'hFF, 32'h0,  1'b0, 8'h00, 1'b0, 1'b1, 32'h0,  3'd0, 1'b0};
    tbl[2]  = '{1'b1, 8'h08, 8'hFF, 32'h9,  1'b1, 8'h08, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[3]  = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b1, 1'b1, 32'h9,  3'd3, 1'b0};
    tbl[4]  = '{1'b1, 8'h02, 8'h02, 32'h5,  1'b0, 8'h02, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'h01, 8'h01, 32'h3,  1'b0, 8'h01, 1'b1, 1'b1, 32'h5,  3'd1, 1'b0};
    tbl[6]  = '{1'b1, 8'h80, 8'h80, 32'h7,  1'b0, 8'h00, 1'b1, 1'b1, 32'h5,  3'd1, 1'b0};
    tbl[7]  = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b1, 1'b1, 32'h5,  3'd1, 1'b0};
    tbl[8]  = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b1, 1'b1, 32'h3,  3'd0, 1'b0};
    tbl[9]  = '{1'b1, 8'h80, 8'h80, 32'h7,  1'b1, 8'h80, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[10] = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b1, 1'b1, 32'h7,  3'd7, 1'b0};
    tbl[11] = '{1'b1, 8'h91, 8'hFF, 32'h0,  1'b1, 8'h00, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[12] = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b0, 1'b0, 32'h0,  3'd0, 1'b1};
    tbl[13] = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[14] = '{1'b1, 8'h10, 8'h10, 32'h40, 1'b1, 8'h10, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[15] = '{1'b1, 8'h10, 8'h10, 32'h41, 1'b1, 8'h10, 1'b1, 1'b1, 32'h40, 3'd4, 1'b0};
    tbl[16] = '{1'b1, 8'h10, 8'h10, 32'h42, 1'b1, 8'h10, 1'b1, 1'b1, 32'h41, 3'd4, 1'b0};
    tbl[17] = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b1, 8'h00, 1'b1, 1'b1, 32'h42, 3'd4, 1'b0};
    tbl[18] = '{1'b1, 8'h04, 8'h00, 32'h0,  1'b1, 8'h00, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[19] = '{1'b1, 8'h04, 8'h04, 32'h20, 1'b0, 8'h04, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0};
    tbl[20] = '{1'b0, 8'h04, 8'h04, 32'h20, 1'b0, 8'h00, 1'b1, 1'b1, 32'h20, 3'd2, 1'b0};
    tbl[21] = '{1'b1, 8'h00, 8'h00, 32'h0,  1'b0, 8'h00, 1'b0, 1'b1, 32'h0,  3'd0, 1'b0};

    m_err = 1'b0;
    for (int j = 0; j < CH; j++) m_stat[j] = 0;

    // Bring registered outputs out of X before the checked reset rows.
    apply(1'b0, 8'h08, 8'hFF, 32'h0, 1'b0);
    cycle_end();

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].g, tbl[i].v, tbl[i].d, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d_ack", i), 128'(in_ack), 128'(tbl[i].ack));
      check($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      if (tbl[i].cd) begin
        check($sformatf("v%0d_out_data", i), 128'(out_data), 128'(tbl[i].od));
        check($sformatf("v%0d_out_chan", i), 128'(out_chan), 128'(tbl[i].oc));
      end
      check($sformatf("v%0d_grant_err", i), 128'(grant_err), 128'(tbl[i].err));
      if (!tbl[i].rst) check($sformatf("v%0d_stats_rst", i), 128'(stat_count), 128'(0));
      model_check();
      cycle_end();
    end

    // Five back-to-back transfers from channel 2 after a fresh reset.
    apply(1'b0, 8'h00, 8'h00, 32'h0, 1'b1);
    cycle_end();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 8'h04, 8'h04, 32'h100 + 32'(i), 1'b1);
      @(negedge clk);
      check("ch2_burst_ack", 128'(in_ack), 128'(8'h04));
      model_check();
      cycle_end();
    end
    apply(1'b1, 8'h00, 8'h00, 32'h0, 1'b1);
    @(negedge clk);
`ifdef RRB_MUX_STATS_EN
    check("stat_ch2", 128'(stat_count[47:32]), 128'(16'd5));
`else
    check("stat_tied_zero", 128'(stat_count), 128'(0));
`endif
    model_check();
    cycle_end();

    // Randomized traffic, including multi-hot grants and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic          r;
      logic [CH-1:0] g, v;
      int unsigned   sel;
      r   = ($urandom_range(63) != 0);
      sel = $urandom_range(9);
      if (sel < 7)       g = CH'(1) << $urandom_range(CH - 1);
      else if (sel == 7) g = '0;
      else               g = CH'($urandom);
      v = CH'($urandom);
      if ($urandom_range(1) == 1) v = v | g;
      apply(r, g, v, $urandom, ($urandom_range(3) != 0));
      @(negedge clk);
      model_check();
      cycle_end();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rrb_grant_mux.md
Name: rrb_grant_mux

Overview:
- Downstream stage of the weighted round-robin arbiter.
- Consumes the arbiter's one-hot grant and the per-channel data buses. Moves the granted channel's word into a 2-entry output buffer and presents it downstream with a valid/ready handshake, tagged with the encoded channel index.
- Acknowledges the source channel on transfer and flags malformed (multi-hot) grants.

Parameters:
- CHANNELS, 8, number of arbitrated channels (matches arbiter channel count)
- WIDTH, 32, data word width per channel
- IDX_W, 3, channel index width; must equal clog2(CHANNELS)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset
- grant  input  CHANNELS  one-hot grant from arbiter; zero means idle
- in_data  input  CHANNELS*WIDTH  channel j data at bits [j*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ack  output  CHANNELS  combinational; one-hot pop to the channel source
- out_data  output  WIDTH  head word
- out_chan  output  IDX_W  channel index of the head word
- out_valid  output  1  buffer non-empty
- out_ready  input  1  downstream accepts head
- grant_err  output  1  registered; multi-hot grant seen last cycle
- stat_count  output  CHANNELS*16  per-channel transfer counters (see Optional Feature)

Behaviour:
- Reset (reset==0 at clk edge):
  - buffer emptied, state EMPTY.
  - out_valid=0, out_data=0, out_chan=0, grant_err=0, stat_count=0.
  - in_ack=0 while reset is low.
- Push condition: grant is exactly one-hot (bit j), in_valid[j]=1, and state!=FULL. Then in_ack[j]=1 in that same cycle, and {in_data[j], j} is written at the edge.
- Full blocks push even if a pop happens the same cycle. There is no combinational ready-through path from out_ready to in_ack.
- Pop condition: out_valid & out_ready. Head advances at the edge.
- Output latency: a pushed word appears on out_data/out_chan with out_valid=1 one cycle after its in_ack cycle when the buffer was empty.
- Ordering: strict FIFO order across channels.
- Head stability: out_data/out_chan hold while out_valid & ~out_ready.
- FSM on occupancy:
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE, and the new word becomes head.
  - FULL: pop -> ONE; no push possible.
- grant==0: no push, no error.
- Grant one-hot but in_valid low: no push, in_ack=0.
- Multi-hot grant: no push, in_ack=0, grant_err=1 for exactly the following cycle. The error is sticky per event only, not latched.
- out_chan is the binary index of the one-hot grant bit; LSB corresponds to channel 0.
- Reset mid-operation: buffered words are discarded. No in_ack is issued in the reset cycle.

Optional Feature:
- Macro: RRB_MUX_STATS_EN.
- Defined: stat_count[j*16 +: 16] increments by 1 on each push from channel j and saturates at 16'hFFFF. It is cleared by reset.
- Undefined: no counter logic; stat_count tied to 0. The port list is identical either way.

Decomposition:
- Shared package rrb_pkg:
  - default CHANNELS/WIDTH constants.
  - clog2 function.
  - occupancy state enum {EMPTY, ONE, FULL}.
  - one-hot-check and one-hot-to-index functions, shared with the arbiter.
- Natural sub-module: rrb_skid_fifo, a 2-entry buffer holding {WIDTH data, IDX_W index} with push/pop/full/empty.
- rrb_grant_mux owns grant decoding, the in_ack logic, error detection and the stats counters.

Test Plan:
- Reset held low 2 cycles with grant=8'b00001000, in_valid=8'hFF -> in_ack=0, out_valid=0, stat_count=0 throughout.
- grant=8'b00001000, in_valid[3]=1, in_data ch3=32'h0000_0009, out_ready=1 -> in_ack=8'b00001000 that cycle. Next cycle: out_valid=1, out_data=32'h9, out_chan=3.
- out_ready=0; grants ch1 (32'h5) then ch0 (32'h3) -> both pushed, state FULL. Third grant ch7 gets in_ack=0. After out_ready=1, output order is ch1 then ch0, then ch7 once re-granted.
- grant=8'b10010001 -> no push, in_ack=0, grant_err=1 for exactly 1 cycle then 0.
- State ONE with out_ready=1 and grant ch4 valid every cycle -> sustained 1 word/cycle, occupancy stays ONE, out_chan=4 each cycle.
- With RRB_MUX_STATS_EN: 5 transfers from ch2 -> stat_count[47:32]=5. Without the macro -> stat_count=0.
